// File: rtl/sparse_round_scheduler.sv
// sparse_round_scheduler
//   Sequences the sparse polynomial multiply controller over every sparse
//   entry of one multiplication. Optionally zeroes the accumulator memory
//   first. It walks the sparse memory addresses, pulses the controller start
//   and waits for its done pulse under a watchdog. It also owns the
//   accumulator-port select so that the clear phase and the controller never
//   drive that port at the same time.
//
//   Optional feature macro: SPARSE_DUMMY_INSERT_EN
//     When defined, every run executes exactly MEM_SPARSE_SIZE iterations.
//     Iterations past num_entries are dummies: they read address 0 and raise
//     dummy_o. This makes the runtime independent of the data.
//
// Ports
//   clk, rst           clock and synchronous active-high reset
//   start              begin a run (sampled in IDLE only)
//   clear_acc          sampled with start; 1 = zero the accumulator first
//   num_entries        valid sparse words, sampled with start
//   busy, done, error  run status (done is a one-cycle pulse, error is sticky)
//   entry_count        real entries completed in the current run
//   sparse_mem_addr_o  sparse memory read address
//   ctrl_start_o       one-cycle start pulse to the controller
//   ctrl_done_i        controller completion pulse
//   acc_sel_o          1 = scheduler owns the accumulator port (CLEAR only)
//   acc_clr_addr_o     clear write address
//   acc_clr_data_o     clear write data (always 0)
//   acc_clr_we_o       clear write enable
//   dummy_o            current iteration is a dummy (feature builds only)
//
// Handshakes
//   start and ctrl_done_i are single-cycle events with no ready path. start
//   is acted on only in IDLE, and ctrl_done_i only in WAIT_DONE. Events in
//   any other state are dropped. ctrl_start_o is high for exactly one cycle
//   (ISSUE) for each iteration.
module sparse_round_scheduler #(
    parameter int WORD_WIDTH      = 32,
    parameter int MEM_SIZE        = 553,
    parameter int MEM_SPARSE_SIZE = 50,
    parameter int TIMEOUT_CYCLES  = 4095
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  clear_acc,
    input  logic [5:0]            num_entries,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [5:0]            entry_count,
    output logic [9:0]            sparse_mem_addr_o,
    output logic                  ctrl_start_o,
    input  logic                  ctrl_done_i,
    output logic                  acc_sel_o,
    output logic [9:0]            acc_clr_addr_o,
    output logic [WORD_WIDTH-1:0] acc_clr_data_o,
    output logic                  acc_clr_we_o,
    output logic                  dummy_o
);
    localparam int              WD_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [5:0]      SPARSE_MAX = 6'(MEM_SPARSE_SIZE);
    localparam logic [9:0]      CLR_LAST   = 10'(MEM_SIZE - 1);
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, LOAD, ISSUE, WAIT_DONE, FINISH, FAULT
    } state_t;

    // The current FSM state. It is visible to hierarchical checkers.
    state_t state, state_next;

    logic [5:0]      num_q, num_d;
    logic [5:0]      iter_q, iter_d;    // iteration index (real + dummy)
    logic [5:0]      entry_q, entry_d;  // real entries completed
    logic [WD_W-1:0] wd_q, wd_d;
    logic [WD_W-1:0] wd_inc;
    logic [9:0]      clr_q, clr_d;
    logic [9:0]      addr_q, addr_d;
    logic            error_q, error_d;

    logic [5:0]      target;
    logic            is_dummy;
    logic [9:0]      load_addr;
    logic            load_issue;        // LOAD that starts another iteration

`ifdef SPARSE_DUMMY_INSERT_EN
    assign target   = SPARSE_MAX;
    assign is_dummy = (iter_q >= num_q);
`else
    assign target   = num_q;
    assign is_dummy = 1'b0;
`endif

    assign load_addr  = is_dummy ? 10'd0 : {4'd0, iter_q};
    assign load_issue = (state == LOAD) && (iter_q != target);
    assign wd_inc     = wd_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            num_q   <= '0;
            iter_q  <= '0;
            entry_q <= '0;
            wd_q    <= '0;
            clr_q   <= '0;
            addr_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state   <= state_next;
            num_q   <= num_d;
            iter_q  <= iter_d;
            entry_q <= entry_d;
            wd_q    <= wd_d;
            clr_q   <= clr_d;
            addr_q  <= addr_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_next = state;
        num_d      = num_q;
        iter_d     = iter_q;
        entry_d    = entry_q;
        wd_d       = wd_q;
        clr_d      = clr_q;
        addr_d     = addr_q;
        error_d    = error_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    num_d   = num_entries;
                    iter_d  = '0;
                    entry_d = '0;
                    clr_d   = '0;
                    error_d = 1'b0;
                    if (num_entries > SPARSE_MAX) begin
                        state_next = FAULT;
                        error_d    = 1'b1;
                    end else if (clear_acc) begin
                        state_next = CLEAR;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            CLEAR: begin
                if (clr_q == CLR_LAST) begin
                    clr_d      = '0;
                    state_next = LOAD;
                end else begin
                    clr_d = clr_q + 10'd1;
                end
            end
            LOAD: begin
                if (iter_q == target) begin
                    state_next = FINISH;
                end else begin
                    // The sync-read memory sees the address this cycle. Its
                    // data is ready when the controller starts in ISSUE.
                    addr_d     = load_addr;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                wd_d       = '0;
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                wd_d = wd_inc;
                // done is checked first, so it wins over a timeout in the
                // same cycle.
                if (ctrl_done_i) begin
                    iter_d = iter_q + 6'd1;
                    if (!is_dummy) begin
                        entry_d = entry_q + 6'd1;
                    end
                    state_next = LOAD;
                end else if (wd_inc == WD_LAST) begin
                    error_d    = 1'b1;
                    state_next = FAULT;
                end
            end
            FINISH:  state_next = IDLE;
            FAULT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy              = (state == CLEAR) || (state == LOAD) ||
                               (state == ISSUE) || (state == WAIT_DONE);
    assign done              = (state == FINISH) || (state == FAULT);
    assign error             = error_q;
    assign entry_count       = entry_q;
    assign sparse_mem_addr_o = load_issue ? load_addr : addr_q;
    assign ctrl_start_o      = (state == ISSUE);
    assign acc_sel_o         = (state == CLEAR);
    assign acc_clr_we_o      = (state == CLEAR);
    assign acc_clr_addr_o    = clr_q;
    assign acc_clr_data_o    = '0;

`ifdef SPARSE_DUMMY_INSERT_EN
    assign dummy_o = is_dummy &&
                     (load_issue || (state == ISSUE) || (state == WAIT_DONE));
`else
    assign dummy_o = 1'b0;
`endif

endmodule

// File: tb/tb_sparse_round_scheduler.sv
module tb_sparse_round_scheduler;
  localparam int WW       = 32;
  localparam int MEM_SIZE = 553;
  localparam int SPARSE   = 50;
  localparam int TMO      = 4095;
  localparam int BUDGET   = 20000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          clear_acc;
  logic [5:0]    num_entries;
  logic          busy;
  logic          done;
  logic          error;
  logic [5:0]    entry_count;
  logic [9:0]    sparse_mem_addr_o;
  logic          ctrl_start_o;
  logic          ctrl_done_i;
  logic          acc_sel_o;
  logic [9:0]    acc_clr_addr_o;
  logic [WW-1:0] acc_clr_data_o;
  logic          acc_clr_we_o;
  logic          dummy_o;

  sparse_round_scheduler #(
    .WORD_WIDTH(WW), .MEM_SIZE(MEM_SIZE),
    .MEM_SPARSE_SIZE(SPARSE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .clear_acc(clear_acc),
    .num_entries(num_entries), .busy(busy), .done(done), .error(error),
    .entry_count(entry_count), .sparse_mem_addr_o(sparse_mem_addr_o),
    .ctrl_start_o(ctrl_start_o), .ctrl_done_i(ctrl_done_i),
    .acc_sel_o(acc_sel_o), .acc_clr_addr_o(acc_clr_addr_o),
    .acc_clr_data_o(acc_clr_data_o), .acc_clr_we_o(acc_clr_we_o),
    .dummy_o(dummy_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- controller model ----------------
  int   ctrl_lat   = 20;
  bit   ctrl_en    = 1'b1;
  bit   force_done = 1'b0;
  int   ctrl_cnt   = 0;
  logic ctrl_hit;

  always @(negedge clk) begin
    ctrl_hit = 1'b0;
    if (rst) begin
      ctrl_cnt = 0;
    end else begin
      if (ctrl_cnt > 0) begin
        ctrl_cnt = ctrl_cnt - 1;
        if (ctrl_cnt == 0) ctrl_hit = 1'b1;
      end
      if (ctrl_start_o && ctrl_en) ctrl_cnt = ctrl_lat;
    end
    ctrl_done_i = ctrl_hit | force_done;
  end

  // ---------------- scoreboard state ----------------
  int vec_count  = 0;
  int miss_count = 0;

  logic [9:0] exp_addr_q[$];
  logic [9:0] exp_clr_q[$];
  logic [9:0] obs_addr_q[$];
  logic [9:0] obs_clr_q[$];

  int obs_done_cycle, obs_busy, obs_starts, obs_dummy, obs_clr_first;
  int obs_clr_last, obs_clr_bad, obs_err_rise, obs_last_start;
  logic       obs_err_at_done;
  logic [5:0] obs_entry_at_done;

  function automatic int iters(input int n);
`ifdef SPARSE_DUMMY_INSERT_EN
    return SPARSE;
`else
    return n;
`endif
  endfunction

  // Expected cycle (counted from the start cycle as 0) of the done pulse.
  function automatic int run_cycles(input bit clr, input int n, input int lat);
    return 1 + (clr ? MEM_SIZE : 0) + iters(n) * (2 + lat) + 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_expect(input bit clr, input int n);
    exp_addr_q.delete();
    exp_clr_q.delete();
    if (clr) for (int a = 0; a < MEM_SIZE; a++) exp_clr_q.push_back(10'(a));
    if (n <= SPARSE)
      for (int i = 0; i < iters(n); i++) exp_addr_q.push_back(i < n ? 10'(i) : 10'd0);
  endtask

  task automatic issue_start(input bit clr, input logic [5:0] n);
    @(posedge clk); #1;
    start = 1'b1; clear_acc = clr; num_entries = n;
    @(posedge clk); #1;
    start = 1'b0;
    clear_acc = 1'($urandom_range(0, 1));
    num_entries = 6'($urandom_range(0, 63));
  endtask

  // Records what the DUT produces from cycle 1 until its done pulse.
  task automatic watch_run(input int budget);
    obs_addr_q.delete(); obs_clr_q.delete();
    obs_done_cycle = -1; obs_busy = 0; obs_starts = 0; obs_dummy = 0;
    obs_clr_first = -1; obs_clr_last = -1; obs_clr_bad = 0;
    obs_err_rise = -1; obs_last_start = -1;
    obs_err_at_done = 1'bx; obs_entry_at_done = 'x;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (busy) obs_busy++;
      if (acc_sel_o !== acc_clr_we_o || acc_clr_data_o !== '0) obs_clr_bad++;
      if (acc_clr_we_o) begin
        obs_clr_q.push_back(acc_clr_addr_o);
        if (obs_clr_first < 0) obs_clr_first = k;
        obs_clr_last = k;
      end
      if (ctrl_start_o) begin
        obs_addr_q.push_back(sparse_mem_addr_o);
        obs_starts++;
        obs_last_start = k;
        if (dummy_o) obs_dummy++;
      end
      if (error === 1'b1 && obs_err_rise < 0) obs_err_rise = k;
      if (done) begin
        obs_done_cycle = k;
        obs_err_at_done = error;
        obs_entry_at_done = entry_count;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    vec_count++;
    if ({busy, done, error, entry_count, sparse_mem_addr_o, ctrl_start_o, acc_sel_o,
         acc_clr_addr_o, acc_clr_data_o, acc_clr_we_o, dummy_o} !== '0) begin
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b cnt=%0d addr=%0d", busy, done,
               error, entry_count, sparse_mem_addr_o);
      miss_count++;
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_clear_run();
    logic [9:0] e, o;
    ctrl_lat = 20;
    push_expect(1'b1, 3);
    issue_start(1'b1, 6'd3);
    watch_run(BUDGET);
    vec_count++;
    if (obs_done_cycle != run_cycles(1'b1, 3, 20)) begin
      $display("FAIL clear_done_cycle: got %0d expected %0d", obs_done_cycle,
               run_cycles(1'b1, 3, 20));
      miss_count++;
    end
    while (exp_clr_q.size() > 0 && obs_clr_q.size() > 0) begin
      e = exp_clr_q.pop_front(); o = obs_clr_q.pop_front();
      vec_count++;
      if (o !== e) begin
        $display("FAIL clear_addr: got %0d expected %0d", o, e);
        miss_count++;
        break;
      end
    end
    vec_count++;
    if (obs_clr_first != 1 || obs_clr_last != MEM_SIZE) begin
      $display("FAIL clear_window: got cycles %0d..%0d expected 1..%0d", obs_clr_first,
               obs_clr_last, MEM_SIZE);
      miss_count++;
    end
    vec_count++;
    if (obs_clr_q.size() != 0 || exp_clr_q.size() != 0) begin
      $display("FAIL clear_count: got %0d extra, %0d missing", obs_clr_q.size(),
               exp_clr_q.size());
      miss_count++;
    end
    vec_count++;
    if (obs_clr_bad != 0) begin
      $display("FAIL clear_sel_data: got %0d bad cycles expected 0", obs_clr_bad);
      miss_count++;
    end
    while (exp_addr_q.size() > 0 && obs_addr_q.size() > 0) begin
      e = exp_addr_q.pop_front(); o = obs_addr_q.pop_front();
      vec_count++;
      if (o !== e) begin
        $display("FAIL clear_run_addr: got %0d expected %0d", o, e);
        miss_count++;
        break;
      end
    end
    vec_count++;
    if (obs_starts != iters(3) || obs_dummy != iters(3) - 3) begin
      $display("FAIL clear_run_starts: got %0d/%0d dummy expected %0d/%0d", obs_starts,
               obs_dummy, iters(3), iters(3) - 3);
      miss_count++;
    end
    vec_count++;
    if (obs_entry_at_done !== 6'd3 || obs_err_at_done !== 1'b0) begin
      $display("FAIL clear_run_status: got cnt=%0d err=%b expected cnt=3 err=0",
               obs_entry_at_done, obs_err_at_done);
      miss_count++;
    end
    vec_count++;
    if (obs_busy != run_cycles(1'b1, 3, 20) - 1) begin
      $display("FAIL clear_run_busy: got %0d expected %0d", obs_busy,
               run_cycles(1'b1, 3, 20) - 1);
      miss_count++;
    end
  endtask

  task automatic test_empty_run();
    ctrl_lat = 3;
    push_expect(1'b0, 0);
    issue_start(1'b0, 6'd0);
    watch_run(BUDGET);
    vec_count++;
    if (obs_done_cycle != run_cycles(1'b0, 0, 3)) begin
      $display("FAIL empty_done_cycle: got %0d expected %0d", obs_done_cycle,
               run_cycles(1'b0, 0, 3));
      miss_count++;
    end
    vec_count++;
    if (obs_starts != iters(0) || obs_clr_q.size() != 0) begin
      $display("FAIL empty_activity: got %0d starts %0d clears expected %0d and 0",
               obs_starts, obs_clr_q.size(), iters(0));
      miss_count++;
    end
    vec_count++;
    if (obs_entry_at_done !== 6'd0 || obs_err_at_done !== 1'b0) begin
      $display("FAIL empty_status: got cnt=%0d err=%b expected 0 0", obs_entry_at_done,
               obs_err_at_done);
      miss_count++;
    end
  endtask

  task automatic test_fault_oversize();
    logic [5:0] bad_n;
    bad_n = 6'($urandom_range(SPARSE + 1, 63));
    for (int r = 0; r < 2; r++) begin
      issue_start(1'b1, r == 0 ? 6'(SPARSE + 1) : bad_n);
      watch_run(BUDGET);
      vec_count++;
      if (obs_done_cycle != 1 || obs_err_at_done !== 1'b1) begin
        $display("FAIL oversize_fault: got done@%0d err=%b expected done@1 err=1",
                 obs_done_cycle, obs_err_at_done);
        miss_count++;
      end
      vec_count++;
      if (obs_starts != 0 || obs_busy != 0 || obs_clr_q.size() != 0) begin
        $display("FAIL oversize_activity: got starts=%0d busy=%0d clr=%0d expected 0",
                 obs_starts, obs_busy, obs_clr_q.size());
        miss_count++;
      end
    end
    vec_count++;
    if (error !== 1'b1) begin
      $display("FAIL error_sticky: got %b expected 1", error);
      miss_count++;
    end
    ctrl_lat = 3;
    issue_start(1'b0, 6'd1);
    watch_run(BUDGET);
    vec_count++;
    if (obs_err_rise != -1 || obs_err_at_done !== 1'b0 || obs_entry_at_done !== 6'd1) begin
      $display("FAIL error_cleared: got rise@%0d err=%b cnt=%0d expected none 0 1",
               obs_err_rise, obs_err_at_done, obs_entry_at_done);
      miss_count++;
    end
  endtask

  task automatic test_timeout();
    ctrl_en = 1'b0;
    issue_start(1'b0, 6'd1);
    watch_run(BUDGET);
    ctrl_en = 1'b1;
    vec_count++;
    if (obs_err_rise - obs_last_start != TMO || obs_done_cycle != obs_err_rise) begin
      $display("FAIL timeout_gap: got start@%0d err@%0d done@%0d expected gap %0d",
               obs_last_start, obs_err_rise, obs_done_cycle, TMO);
      miss_count++;
    end
    vec_count++;
    if (obs_done_cycle != 2 + TMO || obs_starts != 1) begin
      $display("FAIL timeout_done: got done@%0d starts=%0d expected done@%0d starts=1",
               obs_done_cycle, obs_starts, 2 + TMO);
      miss_count++;
    end
    vec_count++;
    if (obs_entry_at_done !== 6'd0 || obs_err_at_done !== 1'b1) begin
      $display("FAIL timeout_status: got cnt=%0d err=%b expected 0 1", obs_entry_at_done,
               obs_err_at_done);
      miss_count++;
    end
  endtask

  // Controller done lands on the last watchdog cycle: done must win.
  task automatic test_done_at_deadline();
    ctrl_lat = TMO - 1;
    issue_start(1'b0, 6'd1);
    watch_run(BUDGET);
    vec_count++;
    if (obs_done_cycle != run_cycles(1'b0, 1, TMO - 1) || obs_err_at_done !== 1'b0 ||
        obs_entry_at_done !== 6'd1) begin
      $display("FAIL deadline_done_wins: got done@%0d err=%b cnt=%0d expected done@%0d 0 1",
               obs_done_cycle, obs_err_at_done, obs_entry_at_done,
               run_cycles(1'b0, 1, TMO - 1));
      miss_count++;
    end
    ctrl_lat = 20;
  endtask

  task automatic test_reset_midrun();
    int seen;
    int active;
    logic [9:0] e, o;
    ctrl_lat = 20;
    seen = 0;
    issue_start(1'b0, 6'd3);
    for (int k = 0; k < 500 && seen < 2; k++) begin
      @(negedge clk);
      if (ctrl_start_o) seen++;
    end
    vec_count++;
    if (seen != 2) begin
      $display("FAIL midrun_second_start: got %0d starts expected 2", seen);
      miss_count++;
    end
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vec_count++;
    if ({busy, done, error, entry_count, sparse_mem_addr_o, ctrl_start_o, acc_sel_o,
         acc_clr_addr_o, acc_clr_we_o, dummy_o} !== '0) begin
      $display("FAIL midrun_reset_outputs: got busy=%b done=%b cnt=%0d addr=%0d", busy,
               done, entry_count, sparse_mem_addr_o);
      miss_count++;
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 force_done = 1'b1;
    @(posedge clk); #1 force_done = 1'b0;
    active = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy || done || ctrl_start_o || entry_count != 0) active++;
    end
    vec_count++;
    if (active != 0) begin
      $display("FAIL idle_spurious_done: got %0d active cycles expected 0", active);
      miss_count++;
    end
    ctrl_lat = 4;
    push_expect(1'b0, 1);
    issue_start(1'b0, 6'd1);
    watch_run(BUDGET);
    e = exp_addr_q.pop_front();
    o = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 10'h3ff;
    vec_count++;
    if (o !== e) begin
      $display("FAIL post_reset_addr: got %0d expected %0d", o, e);
      miss_count++;
    end
    vec_count++;
    if (obs_done_cycle != run_cycles(1'b0, 1, 4) || obs_entry_at_done !== 6'd1) begin
      $display("FAIL post_reset_run: got done@%0d cnt=%0d expected done@%0d cnt=1",
               obs_done_cycle, obs_entry_at_done, run_cycles(1'b0, 1, 4));
      miss_count++;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] n;
    logic [9:0] e, o;
    for (int r = 0; r < 3; r++) begin
      n = 6'($urandom_range(1, 6));
      ctrl_lat = $urandom_range(1, 8);
      push_expect(1'b0, int'(n));
      issue_start(1'b0, n);
      watch_run(BUDGET);
      while (exp_addr_q.size() > 0 && obs_addr_q.size() > 0) begin
        e = exp_addr_q.pop_front(); o = obs_addr_q.pop_front();
        vec_count++;
        if (o !== e) begin
          $display("FAIL b2b_addr: got %0d expected %0d", o, e);
          miss_count++;
          break;
        end
      end
      vec_count++;
      if (obs_done_cycle != run_cycles(1'b0, int'(n), ctrl_lat) ||
          obs_entry_at_done !== n || obs_starts != iters(int'(n))) begin
        $display("FAIL b2b_run: n=%0d got done@%0d cnt=%0d starts=%0d expected done@%0d",
                 n, obs_done_cycle, obs_entry_at_done, obs_starts,
                 run_cycles(1'b0, int'(n), ctrl_lat));
        miss_count++;
      end
    end
  endtask

`ifdef SPARSE_DUMMY_INSERT_EN
  task automatic test_dummy_insert();
    int cyc[2];
    int ns[2];
    logic [9:0] e, o;
    ns[0] = 2; ns[1] = 10;
    ctrl_lat = 5;
    for (int r = 0; r < 2; r++) begin
      push_expect(1'b0, ns[r]);
      issue_start(1'b0, 6'(ns[r]));
      watch_run(BUDGET);
      cyc[r] = obs_done_cycle;
      while (exp_addr_q.size() > 0 && obs_addr_q.size() > 0) begin
        e = exp_addr_q.pop_front(); o = obs_addr_q.pop_front();
        vec_count++;
        if (o !== e) begin
          $display("FAIL dummy_addr: got %0d expected %0d", o, e);
          miss_count++;
          break;
        end
      end
      vec_count++;
      if (obs_starts != SPARSE || obs_dummy != SPARSE - ns[r] ||
          obs_entry_at_done !== 6'(ns[r])) begin
        $display("FAIL dummy_counts: n=%0d got starts=%0d dummy=%0d cnt=%0d", ns[r],
                 obs_starts, obs_dummy, obs_entry_at_done);
        miss_count++;
      end
    end
    vec_count++;
    if (cyc[0] != cyc[1] || cyc[0] != run_cycles(1'b0, 2, 5)) begin
      $display("FAIL dummy_runtime: got %0d and %0d expected %0d", cyc[0], cyc[1],
               run_cycles(1'b0, 2, 5));
      miss_count++;
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; start = 1'b0; clear_acc = 1'b0; num_entries = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_clear_run();
    test_empty_run();
    test_fault_oversize();
    test_timeout();
`ifndef SPARSE_DUMMY_INSERT_EN
    test_done_at_deadline();
`endif
    test_reset_midrun();
    test_back_to_back();
`ifdef SPARSE_DUMMY_INSERT_EN
    test_dummy_insert();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
